// File: rtl/nfc_board_supervisor_if.sv
// rtl/nfc_board_supervisor_if.sv - PLL/reset/LED signal bundle for the board supervisor (optional heartbeat: NFC_SUPERVISOR_HEARTBEAT_EN)
interface nfc_board_supervisor_if #(
  parameter int N_CH = 3
);
  logic              pll_locked;
  logic              sys_rstn;
  logic [N_CH-1:0]   ch_in;
  logic [2*N_CH-1:0] ch_mode;
  logic [N_CH-1:0]   led;
  logic [7:0]        lock_lost_cnt;
`ifdef NFC_SUPERVISOR_HEARTBEAT_EN
  logic              heartbeat;

  modport master (output pll_locked, ch_in, ch_mode,
                  input  sys_rstn, led, lock_lost_cnt, heartbeat);
  modport slave  (input  pll_locked, ch_in, ch_mode,
                  output sys_rstn, led, lock_lost_cnt, heartbeat);
`else
  modport master (output pll_locked, ch_in, ch_mode,
                  input  sys_rstn, led, lock_lost_cnt);
  modport slave  (input  pll_locked, ch_in, ch_mode,
                  output sys_rstn, led, lock_lost_cnt);
`endif
endinterface

// File: rtl/nfc_board_supervisor.sv
// rtl/nfc_board_supervisor.sv - PLL-lock reset sequencer and per-channel LED mode driver (optional heartbeat: NFC_SUPERVISOR_HEARTBEAT_EN)
module nfc_board_supervisor #(
  parameter int N_CH               = 3,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 256,
  parameter int STRETCH_CYCLES     = 8136000,
  parameter int BLINK_HALF_CYCLES  = 40680000
) (
  input  logic                   clk,
  input  logic                   rstn,
  nfc_board_supervisor_if.slave  bus
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);
  localparam int BLK_W  = $clog2(BLINK_HALF_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, HOLD, RUN} state_e;

  state_e            state_q;
  logic [STAB_W-1:0] stab_q;
  logic [HOLD_W-1:0] hold_q;
  logic              sys_rstn_q;
  logic [7:0]        lost_q;
  logic [1:0]        sync_q;
  logic              lk_s;

  // Two-flop synchroniser for the PLL lock, which is asynchronous to clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], bus.pll_locked};
  end

  assign lk_s = sync_q[1];

  // Reset sequencer: the WAIT_LOCK cycle that first sees lock counts as stable cycle one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= WAIT_LOCK;
      stab_q     <= '0;
      hold_q     <= '0;
      sys_rstn_q <= 1'b0;
      lost_q     <= 8'd0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          sys_rstn_q <= 1'b0;
          stab_q     <= '0;
          hold_q     <= '0;
          if (lk_s) begin
            if (LOCK_STABLE_CYCLES == 1) begin
              state_q <= HOLD;
            end else begin
              state_q <= STABILIZE;
              stab_q  <= STAB_W'(1);
            end
          end
        end
        STABILIZE: begin
          sys_rstn_q <= 1'b0;
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
          end else if (stab_q == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
            state_q <= HOLD;
            stab_q  <= '0;
            hold_q  <= '0;
          end else begin
            stab_q <= stab_q + STAB_W'(1);
          end
        end
        HOLD: begin
          sys_rstn_q <= 1'b0;
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
          end else if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
            state_q    <= RUN;
            hold_q     <= '0;
            sys_rstn_q <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state_q    <= WAIT_LOCK;
            sys_rstn_q <= 1'b0;
            if (lost_q != 8'hFF) lost_q <= lost_q + 8'd1;
          end
        end
        default: begin
          state_q    <= WAIT_LOCK;
          sys_rstn_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_rstn      = sys_rstn_q;
  assign bus.lock_lost_cnt = lost_q;

  logic [N_CH-1:0] led_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             prev_q, prev_d;
    logic             led_q, led_d;
    logic             ph_q, ph_d;
    logic [STR_W-1:0] str_q, str_d;
    logic [BLK_W-1:0] blk_q, blk_d;

    // Per-channel display mode; counters of inactive modes are held at zero.
    always_comb begin
      prev_d = bus.ch_in[i];
      led_d  = 1'b0;
      str_d  = '0;
      blk_d  = '0;
      ph_d   = 1'b0;
      case (bus.ch_mode[2*i +: 2])
        2'b00: led_d = bus.ch_in[i];
        2'b01: begin
          if (bus.ch_in[i] && !prev_q) str_d = STR_W'(STRETCH_CYCLES);
          else if (str_q != '0)        str_d = str_q - STR_W'(1);
          led_d = bus.ch_in[i] || (str_q != '0);
        end
        2'b10: begin
          if (bus.ch_in[i]) begin
            led_d = ~ph_q;
            ph_d  = ph_q;
            if (blk_q == BLK_W'(BLINK_HALF_CYCLES - 1)) begin
              blk_d = '0;
              ph_d  = ~ph_q;
            end else begin
              blk_d = blk_q + BLK_W'(1);
            end
          end
        end
        2'b11: led_d = ~bus.ch_in[i];
      endcase
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        prev_q <= 1'b0;
        led_q  <= 1'b0;
        ph_q   <= 1'b0;
        str_q  <= '0;
        blk_q  <= '0;
      end else begin
        prev_q <= prev_d;
        led_q  <= led_d;
        ph_q   <= ph_d;
        str_q  <= str_d;
        blk_q  <= blk_d;
      end
    end

    assign led_vec[i] = led_q;
  end

  assign bus.led = led_vec;

`ifdef NFC_SUPERVISOR_HEARTBEAT_EN
  logic             hb_q, hb_d;
  logic [BLK_W-1:0] hbc_q, hbc_d;

  // Heartbeat toggles only while running; any other state parks it low.
  always_comb begin
    hb_d  = 1'b0;
    hbc_d = '0;
    if (state_q == RUN) begin
      hb_d = hb_q;
      if (hbc_q == BLK_W'(BLINK_HALF_CYCLES - 1)) begin
        hb_d = ~hb_q;
      end else begin
        hbc_d = hbc_q + BLK_W'(1);
      end
    end
  end

  // Heartbeat registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hb_q  <= 1'b0;
      hbc_q <= '0;
    end else begin
      hb_q  <= hb_d;
      hbc_q <= hbc_d;
    end
  end

  assign bus.heartbeat = hb_q;
`endif

endmodule

// File: tb/tb_nfc_board_supervisor.sv
// tb/tb_nfc_board_supervisor.sv - scoreboard bench for nfc_board_supervisor
module tb_nfc_board_supervisor;

  localparam int N_CH = 3;
  localparam int LSC  = 16;
  localparam int RHC  = 8;
  localparam int STR  = 20;
  localparam int BH   = 5;
  localparam int SEQ  = LSC + RHC;

  logic              clk  = 1'b0;
  logic              rstn = 1'b0;
  logic              pll  = 1'b0;
  logic [N_CH-1:0]   ch   = '0;
  logic [2*N_CH-1:0] mode = '0;

  always #5 clk = ~clk;

  nfc_board_supervisor_if #(.N_CH(N_CH)) bus ();
  assign bus.pll_locked = pll;
  assign bus.ch_in      = ch;
  assign bus.ch_mode    = mode;

  nfc_board_supervisor #(
    .N_CH(N_CH), .LOCK_STABLE_CYCLES(LSC), .RST_HOLD_CYCLES(RHC),
    .STRETCH_CYCLES(STR), .BLINK_HALF_CYCLES(BH)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic            rst;
    logic [N_CH-1:0] led;
    logic [7:0]      lost;
    logic            hb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: reset released after SEQ lock samples seen two edges late.
  int  rl_hist[$];
  int  rl_last;
  int  m_lost;
  bit  m_rst_prev;
  int  m_run;
  int  ecount = 0;
  bit  prev_ch[N_CH];
  int  last_rise[N_CH];
  int  burst[N_CH];

  always @(posedge clk) begin : model_p
    exp_t e;
    int   rl;
    bit   r;
    bit   c;
    e = '0;
    ecount++;
    if (!rstn) begin
      rl_hist.delete();
      rl_last    = 0;
      m_lost     = 0;
      m_rst_prev = 1'b0;
      m_run      = 0;
      for (int i = 0; i < N_CH; i++) begin
        prev_ch[i]   = 1'b0;
        last_rise[i] = -1;
        burst[i]     = 0;
      end
    end else begin
      rl = pll ? rl_last + 1 : 0;
      rl_last = rl;
      rl_hist.push_back(rl);
      if (rl_hist.size() > 3) void'(rl_hist.pop_front());
      r = (rl_hist.size() == 3) && (rl_hist[0] >= SEQ);
      if (m_rst_prev && !r && m_lost < 255) m_lost++;
      if (m_rst_prev) begin
        m_run++;
        e.hb = ((m_run / BH) % 2) == 1;
      end else begin
        m_run = 0;
      end
      m_rst_prev = r;
      e.rst  = r;
      e.lost = 8'(m_lost);
      for (int i = 0; i < N_CH; i++) begin
        c = ch[i];
        case (mode[2*i +: 2])
          2'b00: e.led[i] = c;
          2'b11: e.led[i] = !c;
          2'b01: begin
            if (c && !prev_ch[i]) last_rise[i] = ecount;
            e.led[i] = c || (last_rise[i] >= 0 && (ecount - last_rise[i]) <= STR);
          end
          default: begin
            if (c) begin
              burst[i]++;
              e.led[i] = (((burst[i] - 1) / BH) % 2) == 0;
            end else begin
              burst[i] = 0;
            end
          end
        endcase
        prev_ch[i] = c;
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
  always @(negedge clk) begin : monitor_p
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.sys_rstn, bus.led, bus.lock_lost_cnt} !== {e.rst, e.led, e.lost}) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t: got rst=%b led=%b lost=%0d required rst=%b led=%b lost=%0d",
                 $time, bus.sys_rstn, bus.led, bus.lock_lost_cnt, e.rst, e.led, e.lost);
      end
`ifdef NFC_SUPERVISOR_HEARTBEAT_EN
      checks++;
      if (bus.heartbeat !== e.hb) begin
        failures++;
        $display("FAIL heartbeat t=%0t: got %b required %b", $time, bus.heartbeat, e.hb);
      end
`endif
    end
  end

  task automatic drive(input bit p, input logic [N_CH-1:0] c);
    @(negedge clk);
    pll = p;
    ch  = c;
  endtask

  task automatic do_reset(input logic [2*N_CH-1:0] m);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    pll  = 1'b0;
    ch   = '0;
    mode = m;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic measure(input bit lvl, output int n);
    n = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.sys_rstn === lvl) begin
        n = e;
        break;
      end
    end
  endtask

  initial begin : watchdog_p
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim_p
    int n;
    int hi1, hi2, last1, drop;
    logic [2*N_CH-1:0] m;

    @(negedge clk);
    check("reset_sys_rstn", int'(bus.sys_rstn), 0);
    check("reset_led", int'(bus.led), 0);
    check("reset_lost", int'(bus.lock_lost_cnt), 0);

    // Power-up release latency.
    #1 rstn = 1'b1;
    drive(1'b1, '0);
    measure(1'b1, n);
    check("powerup_latency", n, 26);
    check("powerup_lost", int'(bus.lock_lost_cnt), 0);

    // Glitch during STABILIZE restarts the sequence.
    do_reset('0);
    drive(1'b1, '0);
    repeat (8) drive(1'b1, '0);
    repeat (3) drive(1'b0, '0);
    drive(1'b1, '0);
    measure(1'b1, n);
    check("glitch_relatch_latency", n, 26);
    check("glitch_lost", int'(bus.lock_lost_cnt), 0);

    // Loss in RUN.
    drive(1'b0, '0);
    measure(1'b0, n);
    check("loss_latency", n, 3);
    check("loss_count", int'(bus.lock_lost_cnt), 1);

    // Forced losses saturate the counter.
    repeat (300) begin
      repeat (SEQ + 5) drive(1'b1, '0);
      repeat (5) drive(1'b0, '0);
    end
    check("lost_saturated", int'(bus.lock_lost_cnt), 255);

    // Async reset mid-HOLD with a stretch in flight.
    mode = 6'b00_01_00;
    for (int t = 0; t < 20; t++) drive(1'b1, (t == 15) ? 3'b010 : 3'b000);
    @(negedge clk);
    check("pre_reset_stretch_led1", int'(bus.led[1]), 1);
    check("pre_reset_hold_sys_rstn", int'(bus.sys_rstn), 0);
    #1 rstn = 1'b0;
    #1;
    check("async_sys_rstn", int'(bus.sys_rstn), 0);
    check("async_led", int'(bus.led), 0);
    check("async_lost", int'(bus.lock_lost_cnt), 0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    measure(1'b1, n);
    check("post_async_latency", n, 26);

    // Stretch with retrigger and blink burst.
    do_reset(6'b10_01_11);
    hi1 = 0; hi2 = 0; last1 = -1;
    for (int t = 0; t <= 45; t++) begin
      @(negedge clk);
      if (t >= 1) begin
        if (bus.led[1]) begin hi1++; last1 = t; end
        if (bus.led[2]) hi2++;
      end
      pll   = 1'b1;
      ch[1] = (t == 0 || t == 10);
      ch[2] = (t < 22);
      ch[0] = 1'($urandom);
    end
    check("stretch_high_cycles", hi1, 31);
    check("stretch_last_cycle", last1, 31);
    check("blink_high_cycles", hi2, 12);

    // Randomized segments.
    for (int s = 0; s < 8; s++) begin
      m = (s == 0) ? 6'b00_00_00 : (s == 1) ? 6'b11_11_11 : 6'($urandom);
      do_reset(m);
      drop = 0;
      for (int t = 0; t < 250; t++) begin
        if (drop > 0) drop--;
        else if ($urandom_range(0, 59) == 0) drop = $urandom_range(1, 4);
        drive(drop == 0, ch ^ (($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000));
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
